ps2_kbd_rx: RTL
===============

// Module: ps2_kbd_rx
// PURPOSE
//  Parametrised PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deframes 11-bit frames,
//  buffers scan bytes in a first-word-fall-through FIFO and tracks make/break/extended state.
//  Outputs last key, press state and a press counter for the seg_hex display path in top.
//  Successor to the fixed-depth ps2_keyboard: configurable depth, counter width, line timeout.
// PARAMETERS
//  FIFO_DEPTH   8      scan-byte FIFO entries; power of 2, >=2
//  CNT_W        8      width of key_times press counter
//  SYNC_STAGES  3      synchroniser flops on ps2_clk and ps2_data, >=2
//  TIMEOUT_CYC  50000  clk cycles without a ps2_clk falling edge before a partial frame is discarded
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous reset, active-high
//  ps2_clk     in   1       PS/2 clock line (asynchronous)
//  ps2_data    in   1       PS/2 data line (asynchronous)
//  nextdata_n  in   1       active-low pop request; pops head when ready=1
//  data        out  8       FIFO head byte (FWFT), valid when ready=1
//  ready       out  1       FIFO not empty
//  overflow    out  1       sticky: a valid frame was dropped because FIFO was full
//  frame_err   out  1       1-cycle pulse: bad start/stop/parity or timeout
//  key_code    out  8       last make-code received (no E0/F0 prefixes)
//  key_ext     out  1       key_code came with E0 prefix
//  key_pressed out  1       key_code currently held
//  key_times   out  CNT_W   count of distinct key presses, wraps
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, bit counter 0, timeout counter 0.
//  Sampling: falling edge = synchronised ps2_clk 1->0; ps2_data sampled in the same cycle.
//  Frame: bit0 start=0, bits1-8 data LSB first, bit9 odd parity, bit10 stop=1.
//  On 11th edge (cycle N): check frame; good -> FIFO push at end of N, ready=1 in N+1.
//  Bad frame -> frame_err pulses in N+1, byte discarded, bit counter to 0.
//  Timeout: bit counter!=0 and TIMEOUT_CYC cycles with no edge -> counter 0, frame_err pulse.
//  FIFO: pop when !nextdata_n && ready; pop on empty ignored. Push+pop same cycle legal,
//   also when full (no overflow). Push when full without pop -> byte dropped, overflow=1.
//  overflow clears on the cycle the FIFO becomes empty through a pop.
//  Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, rest equal.
//  Decoder FSM runs on every good frame, independent of FIFO occupancy/overflow:
//   IDLE:    E0->EXT; F0->BRK; else make(code,ext=0)
//   EXT:     F0->EXT_BRK; E0->EXT; else make(code,ext=1), ->IDLE
//   BRK:     break(code,ext=0), ->IDLE
//   EXT_BRK: break(code,ext=1), ->IDLE
//  make: if key_pressed && {ext,code}=={key_ext,key_code} (typematic) -> no change;
//   else key_code/key_ext updated, key_pressed=1, key_times+1 (wraps to 0 at 2^CNT_W).
//  break: if {ext,code}=={key_ext,key_code} -> key_pressed=0; key_code/key_ext retained;
//   break of another key ignored.
//  Decoder outputs update at end of cycle N (visible N+1), same as FIFO push.
//  Bad frame or timeout returns FSM to IDLE. Reset mid-frame discards partial frame.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined: parity error counts as bad frame (frame_err, dropped).
//  Not defined: parity bit ignored; only start/stop/timeout errors checked.
// STRUCTURE
//  Package ps2_pkg: SC_EXT=8'hE0, SC_BRK=8'hF0, frame length 11, decoder state enum
//   (IDLE, EXT, BRK, EXT_BRK).
//  Sub-module ps2_byte_fifo (FWFT, DEPTH param); deframer, timeout and decoder FSM inline.
// TESTING
//  Send 8'h1C (A), parity ok -> ready=1, data=1C, key_code=1C, key_pressed=1, key_times=1.
//  Send 1C,1C,1C (typematic), F0,1C -> key_times stays 1, key_pressed=0 after 1C; FIFO holds 5.
//  Send E0,75 then E0,F0,75 -> key_ext=1, key_code=75, key_times+1, then key_pressed=0.
//  FIFO_DEPTH=8, no pops, send 9 bytes -> 9th dropped, overflow=1; pop 8 -> overflow=0 at empty.
//  Bad parity with PS2_PARITY_CHECK_EN -> frame_err pulse, ready unchanged; without -> accepted.
//  Stop after 5 bits, wait TIMEOUT_CYC -> frame_err pulse; next full frame 8'h29 decoded correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and decoder state type for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;  // extended-key prefix
    localparam logic [7:0] SC_BRK    = 8'hF0;  // break (release) prefix
    localparam int         FRAME_LEN = 11;     // start + 8 data + parity + stop

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_e;

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO with sticky overflow flag.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module ps2_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] level;
    logic        ovf_q, ovf_d;
    logic        pop_ok, push_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level   = wr_q - rd_q;

    // Pop on empty is ignored; push while full only lands if a pop frees the slot.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Head byte is shown only while the FIFO holds data, so reset reads as 0.
    assign dout_o     = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];
    assign overflow_o = ovf_q;

    // Next pointer and overflow state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        ovf_d = ovf_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        if (push_i && full_o && !pop_ok)
            ovf_d = 1'b1;
        else if (pop_ok && !push_ok && level == (AW+1)'(1))
            ovf_d = 1'b0;
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: line synchroniser, 11-bit deframer with line
// timeout, scan-byte FIFO and make/break/extended decoder.
// Optional: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             nextdata_n,
    output logic [7:0]       data,
    output logic             ready,
    output logic             overflow,
    output logic             frame_err,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_pressed,
    output logic [CNT_W-1:0] key_times
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    // ---------------- synchroniser / edge detect ----------------
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall, dat_s;

    // Idle PS/2 lines are high, so the chain resets high to avoid a fake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall  = clk_prev_q && !clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // ---------------- deframer / timeout ----------------
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      sr_q, sr_d;        // {parity, data[7:0], start} once 10 bits are in
    logic [TO_W-1:0] to_q, to_d;
    logic            frame_ok, frame_bad, timeout;
    logic            par_ok;
    logic [7:0]      frame_byte;

    assign frame_byte = sr_q[8:1];

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^sr_q[9:1];         // odd parity over data + parity bit
`else
    logic unused_par;
    assign unused_par = sr_q[9];
    assign par_ok     = 1'b1;
`endif

    // Shift bits in on each falling edge; judge the frame on the 11th edge.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        to_d      = to_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        timeout   = 1'b0;
        if (fall) begin
            to_d = '0;
            if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
                bit_cnt_d = '0;
                if (!sr_q[0] && dat_s && par_ok) frame_ok  = 1'b1;
                else                             frame_bad = 1'b1;
            end else begin
                sr_d      = {dat_s, sr_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != '0) begin
            if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                timeout   = 1'b1;
                bit_cnt_d = '0;
                to_d      = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    // Deframer state and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            sr_q      <= '0;
            to_q      <= '0;
            frame_err <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            to_q      <= to_d;
            frame_err <= frame_bad || timeout;
        end
    end

    // ---------------- FIFO ----------------
    logic fifo_empty, fifo_full;

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (frame_ok),
        .din_i      (frame_byte),
        .pop_i      (!nextdata_n),
        .dout_o     (data),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .overflow_o (overflow)
    );

    assign ready = !fifo_empty;

    logic unused_full;
    assign unused_full = fifo_full;

    // ---------------- decoder FSM ----------------
    dec_state_e       state_q, state_d;
    logic [7:0]       key_code_d;
    logic             key_ext_d, key_pressed_d;
    logic [CNT_W-1:0] key_times_d;
    logic             do_make, do_brk, ev_ext;

    // Prefix tracking plus make/break bookkeeping on each good byte.
    always_comb begin
        state_d       = state_q;
        key_code_d    = key_code;
        key_ext_d     = key_ext;
        key_pressed_d = key_pressed;
        key_times_d   = key_times;
        do_make       = 1'b0;
        do_brk        = 1'b0;
        ev_ext        = 1'b0;
        if (frame_bad || timeout) begin
            state_d = IDLE;
        end else if (frame_ok) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_byte == SC_EXT)      state_d = EXT;
                    else if (frame_byte == SC_BRK) state_d = BRK;
                    else                           do_make = 1'b1;
                end
                EXT: begin
                    if (frame_byte == SC_BRK)      state_d = EXT_BRK;
                    else if (frame_byte == SC_EXT) state_d = EXT;
                    else begin
                        do_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    do_brk  = 1'b1;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    do_brk  = 1'b1;
                    ev_ext  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Typematic repeats of the held key leave everything unchanged.
        if (do_make && !(key_pressed && {ev_ext, frame_byte} == {key_ext, key_code})) begin
            key_code_d    = frame_byte;
            key_ext_d     = ev_ext;
            key_pressed_d = 1'b1;
            key_times_d   = key_times + 1'b1;
        end
        if (do_brk && {ev_ext, frame_byte} == {key_ext, key_code})
            key_pressed_d = 1'b0;
    end

    // Decoder registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_pressed <= 1'b0;
            key_times   <= '0;
        end else begin
            state_q     <= state_d;
            key_code    <= key_code_d;
            key_ext     <= key_ext_d;
            key_pressed <= key_pressed_d;
            key_times   <= key_times_d;
        end
    end

endmodule
